// File: rtl/tetris_pkg.sv
// Shared types and default geometry for the falling-piece datapath,
// the playfield and the renderer.
package tetris_pkg;

    localparam int CELL_DEFAULT    = 20;
    localparam int LEFT_X_DEFAULT  = 0;
    localparam int RIGHT_X_DEFAULT = 620;
    localparam int FLOOR_Y_DEFAULT = 480;

    typedef enum logic [2:0] {
        WAIT_SPAWN,
        FALL,
        DROP,
        LOCK,
        OVER
    } fall_state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } square_t;

endpackage

// File: rtl/piece_extent.sv
// Bounding box of a four-square piece.
// Results are widened to 11 bits so callers can add a cell size without wrapping.
module piece_extent
    import tetris_pkg::*;
(
    input  square_t [3:0] i_squares,
    output logic [10:0]   o_min_x,
    output logic [10:0]   o_max_x,
    output logic [10:0]   o_min_y,
    output logic [10:0]   o_max_y
);

    // Seed from square 0, then fold in the remaining three squares.
    always_comb begin
        o_min_x = {1'b0, i_squares[0].x};
        o_max_x = {1'b0, i_squares[0].x};
        o_min_y = {1'b0, i_squares[0].y};
        o_max_y = {1'b0, i_squares[0].y};
        for (int i = 1; i < 4; i++) begin
            if ({1'b0, i_squares[i].x} < o_min_x) o_min_x = {1'b0, i_squares[i].x};
            if ({1'b0, i_squares[i].x} > o_max_x) o_max_x = {1'b0, i_squares[i].x};
            if ({1'b0, i_squares[i].y} < o_min_y) o_min_y = {1'b0, i_squares[i].y};
            if ({1'b0, i_squares[i].y} > o_max_y) o_max_y = {1'b0, i_squares[i].y};
        end
    end

endmodule

// File: rtl/piece_fall_controller.sv
// Sequences the active falling piece.
// It captures a spawn and applies lateral moves and gravity on frame ticks.
// On landing it issues a one-cycle lock write and the at_bottom pulse.
module piece_fall_controller
    import tetris_pkg::*;
#(
    parameter int GRAVITY_TICKS = 30,
    parameter int SOFT_TICKS    = 3,
    parameter int CELL          = CELL_DEFAULT,
    parameter int LEFT_X        = LEFT_X_DEFAULT,
    parameter int RIGHT_X       = RIGHT_X_DEFAULT,
    parameter int FLOOR_Y       = FLOOR_Y_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_frame_tick,
    input  logic       i_coord,
    input  logic [9:0] i_new_square_1x,
    input  logic [9:0] i_new_square_1y,
    input  logic [9:0] i_new_square_2x,
    input  logic [9:0] i_new_square_2y,
    input  logic [9:0] i_new_square_3x,
    input  logic [9:0] i_new_square_3y,
    input  logic [9:0] i_new_square_4x,
    input  logic [9:0] i_new_square_4y,
    input  logic       i_move_left,
    input  logic       i_move_right,
    input  logic       i_soft_drop,
    input  logic       i_occupied_left,
    input  logic       i_occupied_right,
    input  logic       i_occupied_below,
    output logic [9:0] o_piece_1x,
    output logic [9:0] o_piece_1y,
    output logic [9:0] o_piece_2x,
    output logic [9:0] o_piece_2y,
    output logic [9:0] o_piece_3x,
    output logic [9:0] o_piece_3y,
    output logic [9:0] o_piece_4x,
    output logic [9:0] o_piece_4y,
    output logic       o_piece_active,
    output logic       o_at_bottom,
    output logic       o_lock_we,
    output logic       o_game_over
);

    localparam logic [9:0]  CELL_10    = 10'(CELL);
    localparam logic [10:0] CELL_11    = 11'(CELL);
    localparam logic [10:0] LEFT_LIMIT = 11'(LEFT_X + CELL);
    localparam logic [10:0] RIGHT_11   = 11'(RIGHT_X);
    localparam logic [10:0] FLOOR_11   = 11'(FLOOR_Y);
    localparam logic [7:0]  GRAV_8     = 8'(GRAVITY_TICKS);
    localparam logic [7:0]  SOFT_8     = 8'(SOFT_TICKS);

    fall_state_t   r_state;
    fall_state_t   w_next_state;
    square_t [3:0] r_piece;
    square_t [3:0] w_new_piece;
    logic [7:0]    r_count;
    logic [7:0]    w_threshold;
    logic [8:0]    w_count_inc;
    logic          w_count_done;
    logic          r_prev_left;
    logic          r_prev_right;
    logic          r_pend_left;
    logic          r_pend_right;
    logic          w_move_left;
    logic          w_move_right;
    logic          w_landed;
    logic [10:0]   w_min_x;
    logic [10:0]   w_max_x;
    logic [10:0]   w_min_y;
    logic [10:0]   w_max_y;

    assign w_new_piece[0] = '{x: i_new_square_1x, y: i_new_square_1y};
    assign w_new_piece[1] = '{x: i_new_square_2x, y: i_new_square_2y};
    assign w_new_piece[2] = '{x: i_new_square_3x, y: i_new_square_3y};
    assign w_new_piece[3] = '{x: i_new_square_4x, y: i_new_square_4y};

    assign o_piece_1x = r_piece[0].x;
    assign o_piece_1y = r_piece[0].y;
    assign o_piece_2x = r_piece[1].x;
    assign o_piece_2y = r_piece[1].y;
    assign o_piece_3x = r_piece[2].x;
    assign o_piece_3y = r_piece[2].y;
    assign o_piece_4x = r_piece[3].x;
    assign o_piece_4y = r_piece[3].y;

    piece_extent u_extent (
        .i_squares (r_piece),
        .o_min_x   (w_min_x),
        .o_max_x   (w_max_x),
        .o_min_y   (w_min_y),
        .o_max_y   (w_max_y)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= WAIT_SPAWN;
        else         r_state <= w_next_state;
    end

    // Next state, move/land decisions and the state-decoded outputs.
    always_comb begin
        w_next_state   = r_state;
        w_move_left    = 1'b0;
        w_move_right   = 1'b0;
        w_landed       = 1'b0;
        o_piece_active = 1'b0;
        o_at_bottom    = 1'b0;
        o_lock_we      = 1'b0;
        o_game_over    = 1'b0;
        w_threshold    = i_soft_drop ? SOFT_8 : GRAV_8;
        w_count_inc    = {1'b0, r_count} + 9'd1;
        w_count_done   = (w_count_inc >= {1'b0, w_threshold});
        case (r_state)
            WAIT_SPAWN: begin
                if (i_coord) w_next_state = FALL;
            end
            FALL: begin
                o_piece_active = 1'b1;
                if (i_frame_tick) begin
                    w_move_left  = r_pend_left && !i_occupied_left && (w_min_x >= LEFT_LIMIT);
                    w_move_right = !w_move_left && r_pend_right && !i_occupied_right &&
                                   ((w_max_x + CELL_11) <= RIGHT_11);
                    if (w_count_done) w_next_state = DROP;
                end
            end
            DROP: begin
                o_piece_active = 1'b1;
                w_landed       = i_occupied_below || ((w_max_y + CELL_11 + CELL_11) > FLOOR_11);
                w_next_state   = w_landed ? LOCK : FALL;
            end
            LOCK: begin
                o_at_bottom  = 1'b1;
                o_lock_we    = 1'b1;
                w_next_state = (w_min_y == 11'd0) ? OVER : WAIT_SPAWN;
            end
            OVER: begin
                o_game_over = 1'b1;
            end
            default: begin
                w_next_state = WAIT_SPAWN;
            end
        endcase
    end

    // Key edge detection and pending moves; only live while the piece is falling.
    always_ff @(posedge i_clk) begin
        if (i_reset || r_state != FALL) begin
            r_prev_left  <= 1'b0;
            r_prev_right <= 1'b0;
            r_pend_left  <= 1'b0;
            r_pend_right <= 1'b0;
        end else begin
            r_prev_left  <= i_move_left;
            r_prev_right <= i_move_right;
            if (i_frame_tick) begin
                r_pend_left  <= 1'b0;
                r_pend_right <= 1'b0;
            end else begin
                if (i_move_left && !r_prev_left)   r_pend_left  <= 1'b1;
                if (i_move_right && !r_prev_right) r_pend_right <= 1'b1;
            end
        end
    end

    // Gravity tick counter, restarted on spawn and on each gravity step.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (r_state == WAIT_SPAWN && i_coord) begin
            r_count <= '0;
        end else if (r_state == FALL && i_frame_tick) begin
            r_count <= w_count_done ? 8'd0 : w_count_inc[7:0];
        end
    end

    // Piece coordinates: capture on spawn, lateral shift in FALL, one-cell drop in DROP.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_piece <= '0;
        end else begin
            case (r_state)
                WAIT_SPAWN: begin
                    if (i_coord) r_piece <= w_new_piece;
                end
                FALL: begin
                    for (int i = 0; i < 4; i++) begin
                        if (w_move_left)       r_piece[i].x <= r_piece[i].x - CELL_10;
                        else if (w_move_right) r_piece[i].x <= r_piece[i].x + CELL_10;
                    end
                end
                DROP: begin
                    for (int i = 0; i < 4; i++) begin
                        if (!w_landed) r_piece[i].y <= r_piece[i].y + CELL_10;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_fall_controller.sv
// Directed vector bench for piece_fall_controller.
// Each vector is one clock: inputs are driven, the edge occurs, and outputs are then checked.
module tb_piece_fall_controller;

    localparam logic [8:0] NONE = 9'h000;
    localparam logic [8:0] RST  = 9'h100;
    localparam logic [8:0] CRD  = 9'h080;
    localparam logic [8:0] TCK  = 9'h040;
    localparam logic [8:0] ML   = 9'h020;
    localparam logic [8:0] MR   = 9'h010;
    localparam logic [8:0] SD   = 9'h008;
    localparam logic [8:0] OL   = 9'h004;
    localparam logic [8:0] ORT  = 9'h002;
    localparam logic [8:0] OB   = 9'h001;

    // Expected flags {piece_active, at_bottom, lock_we, game_over}.
    localparam logic [3:0] O_IDLE = 4'b0000;
    localparam logic [3:0] O_ACT  = 4'b1000;
    localparam logic [3:0] O_LOCK = 4'b0110;
    localparam logic [3:0] O_OVER = 4'b0001;

    typedef struct {
        string       name;
        logic [8:0]  stim;
        logic [39:0] expX;
        logic [39:0] expY;
        logic [3:0]  expFlags;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, frameTick, coord, moveLeft, moveRight, softDrop;
    logic       occLeft, occRight, occBelow;
    logic [9:0] nx[4];
    logic [9:0] ny[4];
    logic [9:0] p1x, p1y, p2x, p2y, p3x, p3y, p4x, p4y;
    logic       pieceActive, atBottom, lockWe, gameOver;

    int vectorsApplied = 0;
    int miscompares    = 0;

    vec_t tbl[27];

    always #5 clk = ~clk;

    piece_fall_controller #(
        .GRAVITY_TICKS (3),
        .SOFT_TICKS    (2)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_frame_tick     (frameTick),
        .i_coord          (coord),
        .i_new_square_1x  (nx[0]),
        .i_new_square_1y  (ny[0]),
        .i_new_square_2x  (nx[1]),
        .i_new_square_2y  (ny[1]),
        .i_new_square_3x  (nx[2]),
        .i_new_square_3y  (ny[2]),
        .i_new_square_4x  (nx[3]),
        .i_new_square_4y  (ny[3]),
        .i_move_left      (moveLeft),
        .i_move_right     (moveRight),
        .i_soft_drop      (softDrop),
        .i_occupied_left  (occLeft),
        .i_occupied_right (occRight),
        .i_occupied_below (occBelow),
        .o_piece_1x       (p1x),
        .o_piece_1y       (p1y),
        .o_piece_2x       (p2x),
        .o_piece_2y       (p2y),
        .o_piece_3x       (p3x),
        .o_piece_3y       (p3y),
        .o_piece_4x       (p4x),
        .o_piece_4y       (p4y),
        .o_piece_active   (pieceActive),
        .o_at_bottom      (atBottom),
        .o_lock_we        (lockWe),
        .o_game_over      (gameOver)
    );

    // Square 1 sits in the low ten bits.
    function automatic logic [39:0] q4(input int a, input int b, input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic vec_t mk(input string n, input logic [8:0] s, input logic [39:0] x,
                                input logic [39:0] y, input logic [3:0] f);
        vec_t v;
        v.name     = n;
        v.stim     = s;
        v.expX     = x;
        v.expY     = y;
        v.expFlags = f;
        return v;
    endfunction

    function automatic void setSpawn(input logic [39:0] x, input logic [39:0] y);
        for (int i = 0; i < 4; i++) begin
            nx[i] = x[i*10 +: 10];
            ny[i] = y[i*10 +: 10];
        end
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset     = v.stim[8];
        coord     = v.stim[7];
        frameTick = v.stim[6];
        moveLeft  = v.stim[5];
        moveRight = v.stim[4];
        softDrop  = v.stim[3];
        occLeft   = v.stim[2];
        occRight  = v.stim[1];
        occBelow  = v.stim[0];
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        logic [39:0] actX;
        logic [39:0] actY;
        logic [3:0]  actF;
        actX = {p4x, p3x, p2x, p1x};
        actY = {p4y, p3y, p2y, p1y};
        actF = {pieceActive, atBottom, lockWe, gameOver};
        vectorsApplied++;
        if (actX !== v.expX) begin
            miscompares++;
            $display("[TB] FAIL %s x: got %h expected %h", v.name, actX, v.expX);
        end
        if (actY !== v.expY) begin
            miscompares++;
            $display("[TB] FAIL %s y: got %h expected %h", v.name, actY, v.expY);
        end
        if (actF !== v.expFlags) begin
            miscompares++;
            $display("[TB] FAIL %s flags(act,bot,we,over): got %b expected %b",
                     v.name, actF, v.expFlags);
        end
    endtask

    task automatic run(input string n, input logic [8:0] s, input logic [39:0] x,
                       input logic [39:0] y, input logic [3:0] f);
        vec_t v;
        v = mk(n, s, x, y, f);
        applyStimulus(v);
        checkOutput(v);
    endtask

    initial begin
        logic [39:0] xS1, yS1, z0;
        xS1 = q4(300, 320, 300, 320);
        yS1 = q4(0, 0, 20, 20);
        z0  = q4(0, 0, 0, 0);
        setSpawn(xS1, yS1);

        tbl[0]  = mk("reset",        RST,      z0,  z0,  O_IDLE);
        tbl[1]  = mk("spawn",        CRD,      xS1, yS1, O_ACT);
        tbl[2]  = mk("idle",         NONE,     xS1, yS1, O_ACT);
        tbl[3]  = mk("grav_t1",      TCK,      xS1, yS1, O_ACT);
        tbl[4]  = mk("grav_idle",    NONE,     xS1, yS1, O_ACT);
        tbl[5]  = mk("grav_t2",      TCK,      xS1, yS1, O_ACT);
        tbl[6]  = mk("grav_t3",      TCK,      xS1, yS1, O_ACT);
        tbl[7]  = mk("grav_drop",    NONE,     xS1, q4(20, 20, 40, 40), O_ACT);
        tbl[8]  = mk("left_rise",    ML,       xS1, q4(20, 20, 40, 40), O_ACT);
        tbl[9]  = mk("left_move",    TCK,      q4(280, 300, 280, 300), q4(20, 20, 40, 40), O_ACT);
        tbl[10] = mk("lblk_rise",    ML | OL,  q4(280, 300, 280, 300), q4(20, 20, 40, 40), O_ACT);
        tbl[11] = mk("lblk_tick",    TCK | OL, q4(280, 300, 280, 300), q4(20, 20, 40, 40), O_ACT);
        tbl[12] = mk("cnt_t3",       TCK,      q4(280, 300, 280, 300), q4(20, 20, 40, 40), O_ACT);
        tbl[13] = mk("cnt_drop",     NONE,     q4(280, 300, 280, 300), q4(40, 40, 60, 60), O_ACT);
        tbl[14] = mk("both_rise",    ML | MR,  q4(280, 300, 280, 300), q4(40, 40, 60, 60), O_ACT);
        tbl[15] = mk("both_tick",    TCK,      q4(260, 280, 260, 280), q4(40, 40, 60, 60), O_ACT);
        tbl[16] = mk("hold_rise",    MR,       q4(260, 280, 260, 280), q4(40, 40, 60, 60), O_ACT);
        tbl[17] = mk("hold_tick1",   MR | TCK, q4(280, 300, 280, 300), q4(40, 40, 60, 60), O_ACT);
        tbl[18] = mk("hold_idle",    MR,       q4(280, 300, 280, 300), q4(40, 40, 60, 60), O_ACT);
        tbl[19] = mk("hold_tick2",   MR | TCK, q4(280, 300, 280, 300), q4(40, 40, 60, 60), O_ACT);
        tbl[20] = mk("hold_drop",    NONE,     q4(280, 300, 280, 300), q4(60, 60, 80, 80), O_ACT);
        tbl[21] = mk("comb_t1",      TCK,      q4(280, 300, 280, 300), q4(60, 60, 80, 80), O_ACT);
        tbl[22] = mk("comb_t2",      TCK,      q4(280, 300, 280, 300), q4(60, 60, 80, 80), O_ACT);
        tbl[23] = mk("comb_rise",    ML,       q4(280, 300, 280, 300), q4(60, 60, 80, 80), O_ACT);
        tbl[24] = mk("comb_tick",    TCK,      q4(260, 280, 260, 280), q4(60, 60, 80, 80), O_ACT);
        tbl[25] = mk("below_lock",   OB,       q4(260, 280, 260, 280), q4(60, 60, 80, 80), O_LOCK);
        tbl[26] = mk("lock_release", NONE,     q4(260, 280, 260, 280), q4(60, 60, 80, 80), O_IDLE);

        for (int i = 0; i < 27; i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i]);
        end

        // Vertical rod that lands on the floor at its first gravity step.
        setSpawn(q4(100, 100, 100, 100), q4(400, 420, 440, 460));
        run("rod_spawn",  CRD,  q4(100, 100, 100, 100), q4(400, 420, 440, 460), O_ACT);
        run("rod_t1",     TCK,  q4(100, 100, 100, 100), q4(400, 420, 440, 460), O_ACT);
        run("rod_t2",     TCK,  q4(100, 100, 100, 100), q4(400, 420, 440, 460), O_ACT);
        run("rod_t3",     TCK,  q4(100, 100, 100, 100), q4(400, 420, 440, 460), O_ACT);
        run("rod_lock",   NONE, q4(100, 100, 100, 100), q4(400, 420, 440, 460), O_LOCK);
        run("rod_wait",   NONE, q4(100, 100, 100, 100), q4(400, 420, 440, 460), O_IDLE);
        run("rod_wait2",  NONE, q4(100, 100, 100, 100), q4(400, 420, 440, 460), O_IDLE);

        // Piece against the left wall; a tick during DROP must not count.
        setSpawn(q4(0, 20, 0, 20), q4(100, 100, 120, 120));
        run("wall_spawn", CRD,       q4(0, 20, 0, 20),   q4(100, 100, 120, 120), O_ACT);
        run("wall_rise",  ML,        q4(0, 20, 0, 20),   q4(100, 100, 120, 120), O_ACT);
        run("wall_tick",  TCK,       q4(0, 20, 0, 20),   q4(100, 100, 120, 120), O_ACT);
        run("right_rise", MR,        q4(0, 20, 0, 20),   q4(100, 100, 120, 120), O_ACT);
        run("right_tick", TCK,       q4(20, 40, 20, 40), q4(100, 100, 120, 120), O_ACT);
        run("wall_t3",    TCK,       q4(20, 40, 20, 40), q4(100, 100, 120, 120), O_ACT);
        run("drop_tick",  TCK,       q4(20, 40, 20, 40), q4(120, 120, 140, 140), O_ACT);
        run("post_t1",    TCK,       q4(20, 40, 20, 40), q4(120, 120, 140, 140), O_ACT);
        run("post_t2",    TCK,       q4(20, 40, 20, 40), q4(120, 120, 140, 140), O_ACT);
        run("post_idle",  NONE,      q4(20, 40, 20, 40), q4(120, 120, 140, 140), O_ACT);
        run("post_t3",    TCK,       q4(20, 40, 20, 40), q4(120, 120, 140, 140), O_ACT);
        run("post_drop",  NONE,      q4(20, 40, 20, 40), q4(140, 140, 160, 160), O_ACT);
        run("rblk_rise",  MR,        q4(20, 40, 20, 40), q4(140, 140, 160, 160), O_ACT);
        run("rblk_tick",  TCK | ORT, q4(20, 40, 20, 40), q4(140, 140, 160, 160), O_ACT);
        run("rst_t2",     TCK,       q4(20, 40, 20, 40), q4(140, 140, 160, 160), O_ACT);
        run("rst_t3",     TCK,       q4(20, 40, 20, 40), q4(140, 140, 160, 160), O_ACT);
        run("rst_in_drop", RST | OB, z0, z0, O_IDLE);
        run("rst_after",  NONE,      z0, z0, O_IDLE);

        // Spawn at the top row and land immediately: game over.
        setSpawn(xS1, yS1);
        run("go_spawn",   CRD,       xS1, yS1, O_ACT);
        run("go_t1",      TCK,       xS1, yS1, O_ACT);
        run("go_t2",      TCK,       xS1, yS1, O_ACT);
        run("go_t3",      TCK,       xS1, yS1, O_ACT);
        run("go_lock",    OB,        xS1, yS1, O_LOCK);
        run("go_over",    NONE,      xS1, yS1, O_OVER);
        setSpawn(q4(40, 40, 40, 40), q4(200, 220, 240, 260));
        run("go_ignore",  CRD | ML | TCK, xS1, yS1, O_OVER);
        run("go_sticky",  NONE,      xS1, yS1, O_OVER);
        run("go_reset",   RST,       z0,  z0,  O_IDLE);

        // Soft drop shortens the gravity period to two ticks.
        setSpawn(xS1, yS1);
        run("sd_spawn",   CRD,       xS1, yS1, O_ACT);
        run("sd_t1",      SD | TCK,  xS1, yS1, O_ACT);
        run("sd_idle",    SD,        xS1, yS1, O_ACT);
        run("sd_t2",      SD | TCK,  xS1, yS1, O_ACT);
        run("sd_drop1",   SD,        xS1, q4(20, 20, 40, 40), O_ACT);
        run("sd_t3",      SD | TCK,  xS1, q4(20, 20, 40, 40), O_ACT);
        run("sd_t4",      SD | TCK,  xS1, q4(20, 20, 40, 40), O_ACT);
        run("sd_drop2",   NONE,      xS1, q4(40, 40, 60, 60), O_ACT);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
